// File: rtl/shift_reg_sequencer_if.sv
// Handshake and serial-stream signals between a user block and the
// shift register sequencer. The sequencer connects through the slave modport.
interface shift_reg_sequencer_if #(
  parameter int DATA_LENGTH = 4
);
  logic                   tx_valid;
  logic [DATA_LENGTH-1:0] tx_data;
  logic                   tx_ready;
  logic                   rx_start;
  logic                   ser_in;
  logic                   rx_valid;
  logic [DATA_LENGTH-1:0] rx_data;
  logic                   rx_ready;
  logic                   abort;
  logic                   ser_out;
  logic                   ser_out_valid;
  logic                   busy;

  modport slave (
    input  tx_valid, tx_data, rx_start, ser_in, rx_ready, abort,
    output tx_ready, rx_valid, rx_data, ser_out, ser_out_valid, busy
  );

  modport master (
    output tx_valid, tx_data, rx_start, ser_in, rx_ready, abort,
    input  tx_ready, rx_valid, rx_data, ser_out, ser_out_valid, busy
  );
endinterface

// File: rtl/shift_reg_sequencer.sv
// Sequencer for an external parallel/serial shift register.
// TX: parallel word in, LSB-first serial out. RX: LSB-first serial in, parallel word out.
// The external register holds the only copy of the data; this block drives its control pins.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// CLEAR    | register cleared; entered on reset and abort
// IDLE     | waiting; offers tx_ready, register follows tx_data
// SHIFT_TX | shifting the loaded word out on ser_out
// SHIFT_RX | shifting ser_in into the register
// RX_DONE  | received word presented on rx_data until rx_ready
module shift_reg_sequencer #(
  parameter int DATA_LENGTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  shift_reg_sequencer_if.slave   bus,
  output logic                   reg_sel,
  output logic                   reg_reset,
  output logic [DATA_LENGTH-1:0] reg_din,
  output logic                   reg_din_serie,
  input  logic [DATA_LENGTH-1:0] reg_dout
);

  localparam int CW = $clog2(DATA_LENGTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_LENGTH - 1);

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    SHIFT_TX,
    SHIFT_RX,
    RX_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic tx_ready, rx_valid, ser_out, ser_out_valid;

  // State and bit counter; reset parks the FSM in CLEAR so the register gets wiped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state, counter and register control decode.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    tx_ready      = 1'b0;
    rx_valid      = 1'b0;
    ser_out       = 1'b0;
    ser_out_valid = 1'b0;
    reg_sel       = 1'b0;
    reg_reset     = 1'b0;
    reg_din       = '0;
    reg_din_serie = 1'b0;
    case (state)
      CLEAR: begin
        reg_reset = 1'b1;
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
      IDLE: begin
        tx_ready = !bus.abort;
        reg_din  = bus.tx_data;
        cnt_nxt  = '0;
        if (bus.tx_valid)      state_nxt = SHIFT_TX;
        else if (bus.rx_start) state_nxt = SHIFT_RX;
      end
      SHIFT_TX: begin
        reg_sel       = 1'b1;
        ser_out_valid = 1'b1;
        ser_out       = reg_dout[0];
        cnt_nxt       = cnt + CW'(1);
        if (cnt == CNT_LAST) state_nxt = IDLE;
      end
      SHIFT_RX: begin
        reg_sel       = 1'b1;
        reg_din_serie = bus.ser_in;
        cnt_nxt       = cnt + CW'(1);
        if (cnt == CNT_LAST) state_nxt = RX_DONE;
      end
      RX_DONE: begin
        rx_valid = 1'b1;
        reg_din  = reg_dout;
        if (bus.rx_ready) state_nxt = IDLE;
      end
      default: state_nxt = CLEAR;
    endcase
    // abort overrides every transition, including the IDLE accept
    if (bus.abort && state != CLEAR) state_nxt = CLEAR;
  end

  assign bus.tx_ready      = tx_ready;
  assign bus.rx_valid      = rx_valid;
  assign bus.rx_data       = reg_dout;
  assign bus.ser_out       = ser_out;
  assign bus.ser_out_valid = ser_out_valid;
  assign bus.busy          = (state != IDLE);

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Directed bench for shift_reg_sequencer with a behavioural model of the
// external shift register (sync clear, parallel load, right shift, serial in at MSB).
module tb_shift_reg_sequencer;

  logic       clk;
  logic       reset;
  logic       reg_sel, reg_reset, reg_din_serie;
  logic [3:0] reg_din;
  logic [3:0] reg_q;

  int n_tests = 0;
  int n_fail  = 0;

  shift_reg_sequencer_if #(.DATA_LENGTH(4)) bus ();

  shift_reg_sequencer #(.DATA_LENGTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .reg_sel       (reg_sel),
    .reg_reset     (reg_reset),
    .reg_din       (reg_din),
    .reg_din_serie (reg_din_serie),
    .reg_dout      (reg_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external shift register
  always @(posedge clk) begin
    if (reg_reset)     reg_q <= 4'b0000;
    else if (!reg_sel) reg_q <= reg_din;
    else               reg_q <= {reg_din_serie, reg_q[3:1]};
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // checks one transmitted frame; word was accepted on the previous edge
  task automatic check_tx_frame(input string tag, input logic [3:0] w);
    for (int k = 0; k < 4; k++) begin
      sample();
      check_eq({tag, "_sov"}, 32'(bus.ser_out_valid), 32'd1);
      check_eq({tag, "_bit"}, 32'(bus.ser_out), 32'(w[k]));
      step();
    end
    sample();
    check_eq({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    check_eq({tag, "_idle_sov"}, 32'(bus.ser_out_valid), 32'd0);
  endtask

  task automatic send_word(input logic [3:0] w);
    bus.tx_data  = w;
    bus.tx_valid = 1'b1;
    sample();
    check_eq("tx_accept_ready", 32'(bus.tx_ready), 32'd1);
    step();
    bus.tx_valid = 1'b0;
  endtask

  logic [3:0] rx_bits;

  initial begin
    reset        = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 4'b0000;
    bus.rx_start = 1'b0;
    bus.ser_in   = 1'b0;
    bus.rx_ready = 1'b0;
    bus.abort    = 1'b0;

    // 1. reset and release
    step(); step();
    sample();
    check_eq("rst_reg_reset", 32'(reg_reset), 32'd1);
    check_eq("rst_busy", 32'(bus.busy), 32'd1);
    check_eq("rst_tx_ready", 32'(bus.tx_ready), 32'd0);
    step();
    reset = 1'b1;
    sample();
    check_eq("clear_reg_reset", 32'(reg_reset), 32'd1);
    step();
    sample();
    check_eq("idle_reg_reset", 32'(reg_reset), 32'd0);
    check_eq("idle_tx_ready", 32'(bus.tx_ready), 32'd1);
    check_eq("idle_busy", 32'(bus.busy), 32'd0);
    check_eq("idle_dout", 32'(reg_q), 32'd0);
    step();

    // 2. transmit 1011 -> 1,1,0,1
    send_word(4'b1011);
    check_tx_frame("tx1011", 4'b1011);
    step();

    // 3. receive 1,1,0,0 -> 0011
    bus.rx_start = 1'b1;
    step();
    bus.rx_start = 1'b0;
    rx_bits = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      bus.ser_in = rx_bits[k];
      sample();
      check_eq("rx_shift_busy", 32'(bus.busy), 32'd1);
      check_eq("rx_shift_valid", 32'(bus.rx_valid), 32'd0);
      step();
    end
    bus.ser_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample();
      check_eq("rx_hold_valid", 32'(bus.rx_valid), 32'd1);
      check_eq("rx_hold_data", 32'(bus.rx_data), 32'h3);
      step();
    end
    bus.rx_ready = 1'b1;
    sample();
    check_eq("rx_take_valid", 32'(bus.rx_valid), 32'd1);
    check_eq("rx_take_data", 32'(bus.rx_data), 32'h3);
    step();
    bus.rx_ready = 1'b0;
    sample();
    check_eq("rx_after_valid", 32'(bus.rx_valid), 32'd0);
    check_eq("rx_after_busy", 32'(bus.busy), 32'd0);
    step();

    // 4. tx_valid and rx_start together: TX only
    bus.rx_start = 1'b1;
    send_word(4'b0101);
    bus.rx_start = 1'b0;
    check_tx_frame("both", 4'b0101);
    for (int k = 0; k < 6; k++) begin
      step();
      sample();
      check_eq("both_no_rx", 32'(bus.rx_valid), 32'd0);
      check_eq("both_no_busy", 32'(bus.busy), 32'd0);
    end
    step();

    // 5. abort on 2nd SHIFT_TX cycle
    send_word(4'b1001);
    step();
    bus.abort = 1'b1;
    sample();
    check_eq("abort_in_tx_sov", 32'(bus.ser_out_valid), 32'd1);
    step();
    bus.abort = 1'b0;
    sample();
    check_eq("abort_clear_reset", 32'(reg_reset), 32'd1);
    check_eq("abort_clear_busy", 32'(bus.busy), 32'd1);
    check_eq("abort_clear_sov", 32'(bus.ser_out_valid), 32'd0);
    step();
    sample();
    check_eq("abort_idle_dout", 32'(reg_q), 32'd0);
    check_eq("abort_idle_ready", 32'(bus.tx_ready), 32'd1);
    step();
    send_word(4'b0110);
    check_tx_frame("tx0110", 4'b0110);
    step();
    // abort beats the accept in IDLE
    bus.tx_data  = 4'b1111;
    bus.tx_valid = 1'b1;
    bus.abort    = 1'b1;
    sample();
    check_eq("abort_idle_txready", 32'(bus.tx_ready), 32'd0);
    step();
    bus.tx_valid = 1'b0;
    bus.abort    = 1'b0;
    sample();
    check_eq("abort_idle_to_clear", 32'(reg_reset), 32'd1);
    check_eq("abort_idle_no_tx", 32'(bus.ser_out_valid), 32'd0);
    step();

    // 6. reset during SHIFT_RX
    bus.rx_start = 1'b1;
    step();
    bus.rx_start = 1'b0;
    bus.ser_in   = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    check_eq("mid_rst_reg_reset", 32'(reg_reset), 32'd1);
    check_eq("mid_rst_busy", 32'(bus.busy), 32'd1);
    check_eq("mid_rst_tx_ready", 32'(bus.tx_ready), 32'd0);
    check_eq("mid_rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check_eq("mid_rst_sov", 32'(bus.ser_out_valid), 32'd0);
    check_eq("mid_rst_sel", 32'(reg_sel), 32'd0);
    step();
    reset      = 1'b1;
    bus.ser_in = 1'b0;
    sample();
    check_eq("post_rst_clear", 32'(reg_reset), 32'd1);
    step();
    sample();
    check_eq("post_rst_idle_busy", 32'(bus.busy), 32'd0);
    check_eq("post_rst_idle_ready", 32'(bus.tx_ready), 32'd1);
    check_eq("post_rst_dout", 32'(reg_q), 32'd0);
    for (int k = 0; k < 6; k++) begin
      step();
      sample();
      check_eq("post_rst_no_rx", 32'(bus.rx_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
